// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: gathers five serial operand words into a registered
// A..E group for a downstream adder tree and tags the tree's result.
//
// Handshake: a word is taken on a rising edge where in_valid & in_ready.
// in_ready depends only on en, abort and rst_n (never on in_valid), so a
// source may hold in_valid high indefinitely while in_ready is low.
module adder_tree_feeder #(
  parameter int W   = 16,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         abort,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic [W-1:0] E,
  output logic         launch,
  output logic         sum_valid,
  output logic [7:0]   sum_tag,
  output logic [7:0]   grp_cnt,
  output logic [3:0]   fsm_state
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;
  typedef logic [LAT-1:0]   vld_pipe_t;
  typedef logic [8*LAT-1:0] tag_pipe_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] slot;
  logic [2:0] slot_nx;
  logic       accept;
  logic       last_word;
  logic [W-1:0] stage [4];
  logic [7:0] launch_tag;
  vld_pipe_t  vld_pipe;
  tag_pipe_t  tag_pipe;

  assign accept    = in_valid & in_ready;
  assign last_word = accept & (slot == 3'd4);

  // Debug view of the FSM: {in FILL, slot}.
  assign fsm_state = {(state == FILL), slot};

  // FSM state register: state and slot position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      slot  <= 3'd0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
    end
  end

  // FSM next state: en gates IDLE/FILL; slot advances per accept, abort rewinds it.
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    case (state)
      IDLE:    if (en)  state_nx = FILL;
      FILL:    if (!en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort)
      slot_nx = 3'd0;
    else if (accept)
      slot_nx = (slot == 3'd4) ? 3'd0 : slot + 3'd1;
  end

  // FSM outputs: ready while enabled, not aborting and out of reset.
  always_comb begin
    in_ready = en & ~abort & rst_n;
  end

  // Staging of words 0..3; an abort drops whatever was gathered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) stage[i] <= '0;
    end else if (abort) begin
      for (int i = 0; i < 4; i++) stage[i] <= '0;
    end else if (accept && slot != 3'd4) begin
      stage[slot[1:0]] <= in_data;
    end
  end

  // Operand registers, launch pulse and group counter update together on word 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A          <= '0;
      B          <= '0;
      C          <= '0;
      D          <= '0;
      E          <= '0;
      launch     <= 1'b0;
      launch_tag <= 8'd0;
      grp_cnt    <= 8'd0;
    end else begin
      launch <= last_word;
      if (last_word) begin
        A          <= stage[0];
        B          <= stage[1];
        C          <= stage[2];
        D          <= stage[3];
        E          <= in_data;
        launch_tag <= grp_cnt;
        grp_cnt    <= grp_cnt + 8'd1;
      end
    end
  end

  // Valid/tag shift register tracking the adder tree's latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | vld_pipe_t'(launch);
      tag_pipe <= (tag_pipe << 8) | tag_pipe_t'(launch_tag);
    end
  end

  assign sum_valid = vld_pipe[LAT-1];
  assign sum_tag   = tag_pipe[8*LAT-1 -: 8];

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder with a behavioural 3-stage adder tree.
module tb_adder_tree_feeder;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         abort;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B, C, D, E;
  logic         launch;
  logic         sum_valid;
  logic [7:0]   sum_tag;
  logic [7:0]   grp_cnt;
  logic [3:0]   fsm_state;

  int checks;
  int failures;
  int cyc;

  // Tree model and observation queues.
  int         tp0, tp1, tp2;
  int         launch_cyc_q[$];
  int         sv_cyc_q[$];
  logic [7:0] sv_tag_q[$];
  int         sv_sum_q[$];
  logic [W-1:0] exp_q[$];

  adder_tree_feeder #(.W(W), .LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .D(D), .E(E),
    .launch(launch), .sum_valid(sum_valid), .sum_tag(sum_tag),
    .grp_cnt(grp_cnt), .fsm_state(fsm_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Three registered adder stages fed by A..E.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp0 <= 0; tp1 <= 0; tp2 <= 0;
    end else begin
      tp0 <= int'(A) + int'(B) + int'(C) + int'(D) + int'(E);
      tp1 <= tp0;
      tp2 <= tp1;
    end
  end

  // Record launch and sum_valid events away from the active edge.
  always @(negedge clk) begin
    if (launch) launch_cyc_q.push_back(cyc);
    if (sum_valid) begin
      sv_cyc_q.push_back(cyc);
      sv_tag_q.push_back(sum_tag);
      sv_sum_q.push_back(tp2);
    end
  end

  task automatic clear_q();
    launch_cyc_q.delete();
    sv_cyc_q.delete();
    sv_tag_q.delete();
    sv_sum_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; abort = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0d exp=0", in_ready); end
    checks++; if ({launch, sum_valid, sum_tag, grp_cnt} !== 18'd0) begin failures++; $display("FAIL reset_ctrl got=%0h exp=0", {launch, sum_valid, sum_tag, grp_cnt}); end
    checks++; if ({A, B, C, D, E} !== 80'd0) begin failures++; $display("FAIL reset_operands got=%0h exp=0", {A, B, C, D, E}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0d exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (fsm_state !== 4'b1000) begin failures++; $display("FAIL release_fsm got=%0b exp=1000", fsm_state); end
  endtask

  task automatic test_basic();
    int c5;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 4; i++) send(W'(i));
    checks++; if (launch_cyc_q.size() != 0 || launch !== 1'b0) begin failures++; $display("FAIL basic_early_launch got=%0d exp=0", launch_cyc_q.size()); end
    send(16'd5);
    c5 = cyc;
    checks++; if (launch !== 1'b1) begin failures++; $display("FAIL basic_launch got=%0d exp=1", launch); end
    checks++; if ({A, B, C, D, E} !== {16'd1, 16'd2, 16'd3, 16'd4, 16'd5}) begin failures++; $display("FAIL basic_operands got=%0h exp=00010002000300040005", {A, B, C, D, E}); end
    idle(1);
    checks++; if (launch !== 1'b0) begin failures++; $display("FAIL basic_launch_pulse got=%0d exp=0", launch); end
    idle(5);
    checks++; if (sv_cyc_q.size() != 1) begin failures++; $display("FAIL basic_sum_count got=%0d exp=1", sv_cyc_q.size()); end
    checks++; if ((sv_cyc_q.size() > 0 ? sv_cyc_q[0] - c5 : -1) != 3) begin failures++; $display("FAIL basic_sum_latency got=%0d exp=3", sv_cyc_q.size() > 0 ? sv_cyc_q[0] - c5 : -1); end
    checks++; if ((sv_tag_q.size() > 0 ? sv_tag_q[0] : 8'hff) !== 8'd0) begin failures++; $display("FAIL basic_sum_tag got=%0d exp=0", sv_tag_q.size() > 0 ? sv_tag_q[0] : 8'hff); end
    checks++; if ((sv_sum_q.size() > 0 ? sv_sum_q[0] : -1) != 15) begin failures++; $display("FAIL basic_tree_sum got=%0d exp=15", sv_sum_q.size() > 0 ? sv_sum_q[0] : -1); end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset();
    en = 1'b1;
    for (int i = 10; i <= 14; i++) send(W'(i));
    for (int i = 20; i <= 24; i++) send(W'(i));
    idle(8);
    exp_q.push_back(16'd60);
    exp_q.push_back(16'd110);
    checks++; if (launch_cyc_q.size() != 2) begin failures++; $display("FAIL b2b_launch_count got=%0d exp=2", launch_cyc_q.size()); end
    checks++; if ((launch_cyc_q.size() == 2 ? launch_cyc_q[1] - launch_cyc_q[0] : -1) != 5) begin failures++; $display("FAIL b2b_launch_spacing got=%0d exp=5", launch_cyc_q.size() == 2 ? launch_cyc_q[1] - launch_cyc_q[0] : -1); end
    checks++; if (sv_sum_q.size() != 2) begin failures++; $display("FAIL b2b_sum_count got=%0d exp=2", sv_sum_q.size()); end
    bad = 0;
    for (int i = 0; i < 2 && i < sv_sum_q.size(); i++) begin
      if (sv_sum_q[i] != int'(exp_q[i]) || sv_tag_q[i] !== 8'(i)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_sums_tags got=%0d_bad exp=0_bad", bad); end
  endtask

  task automatic test_abort();
    do_reset();
    en = 1'b1;
    send(16'd1); send(16'd2); send(16'd3);
    abort = 1'b1; in_valid = 1'b1; in_data = 16'd99;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_in_ready got=%0d exp=0", in_ready); end
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    checks++; if (fsm_state !== 4'b1000) begin failures++; $display("FAIL abort_slot got=%0b exp=1000", fsm_state); end
    for (int i = 0; i < 5; i++) send(16'd7);
    idle(5);
    checks++; if (launch_cyc_q.size() != 1) begin failures++; $display("FAIL abort_launch_count got=%0d exp=1", launch_cyc_q.size()); end
    checks++; if ({A, B, C, D, E} !== {5{16'd7}}) begin failures++; $display("FAIL abort_operands got=%0h exp=00070007000700070007", {A, B, C, D, E}); end
    checks++; if ((sv_sum_q.size() == 1 ? sv_sum_q[0] : -1) != 35) begin failures++; $display("FAIL abort_sum got=%0d exp=35", sv_sum_q.size() == 1 ? sv_sum_q[0] : -1); end
  endtask

  task automatic test_en_pause();
    do_reset();
    en = 1'b1;
    send(16'd100); send(16'd101);
    en = 1'b0; in_valid = 1'b1; in_data = 16'd555;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pause_in_ready cycle=%0d got=%0d exp=0", i, in_ready); end
      @(posedge clk); #1;
    end
    checks++; if (fsm_state !== 4'b0010) begin failures++; $display("FAIL pause_fsm got=%0b exp=0010", fsm_state); end
    en = 1'b1; in_valid = 1'b0;
    send(16'd102); send(16'd103); send(16'd104);
    checks++; if ({A, B, C, D, E} !== {16'd100, 16'd101, 16'd102, 16'd103, 16'd104}) begin failures++; $display("FAIL pause_operands got=%0h exp=00640065006600670068", {A, B, C, D, E}); end
    idle(5);
    checks++; if ((sv_sum_q.size() == 1 ? sv_sum_q[0] : -1) != 510) begin failures++; $display("FAIL pause_sum got=%0d exp=510", sv_sum_q.size() == 1 ? sv_sum_q[0] : -1); end
  endtask

  task automatic test_wrap();
    int bad;
    do_reset();
    en = 1'b1;
    for (int g = 0; g < 256; g++)
      for (int w = 0; w < 5; w++) send(W'(g + w));
    checks++; if (grp_cnt !== 8'd0) begin failures++; $display("FAIL wrap_grp_cnt got=%0d exp=0", grp_cnt); end
    idle(5);
    checks++; if (sv_tag_q.size() != 256) begin failures++; $display("FAIL wrap_sum_count got=%0d exp=256", sv_tag_q.size()); end
    bad = 0;
    for (int i = 0; i < sv_tag_q.size(); i++) if (sv_tag_q[i] !== 8'(i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_tag_seq got=%0d_bad exp=0_bad", bad); end
    for (int w = 1; w <= 5; w++) send(W'(w));
    idle(5);
    checks++; if ((sv_tag_q.size() == 257 ? sv_tag_q[256] : 8'hff) !== 8'd0) begin failures++; $display("FAIL wrap_257_tag got=%0d exp=0", sv_tag_q.size() == 257 ? sv_tag_q[256] : 8'hff); end
    checks++; if (grp_cnt !== 8'd1) begin failures++; $display("FAIL wrap_257_grp_cnt got=%0d exp=1", grp_cnt); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    en = 1'b1;
    for (int w = 1; w <= 5; w++) send(W'(w));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({launch, sum_valid, sum_tag, grp_cnt, in_ready} !== 19'd0) begin failures++; $display("FAIL inflight_ctrl got=%0h exp=0", {launch, sum_valid, sum_tag, grp_cnt, in_ready}); end
    checks++; if ({A, B, C, D, E} !== 80'd0) begin failures++; $display("FAIL inflight_operands got=%0h exp=0", {A, B, C, D, E}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    idle(8);
    checks++; if (sv_cyc_q.size() != 0) begin failures++; $display("FAIL inflight_stale_sum got=%0d exp=0", sv_cyc_q.size()); end
    for (int w = 0; w < 5; w++) send(16'd2);
    idle(5);
    checks++; if ((sv_sum_q.size() == 1 ? sv_sum_q[0] : -1) != 10 || (sv_tag_q.size() == 1 ? sv_tag_q[0] : 8'hff) !== 8'd0) begin failures++; $display("FAIL inflight_new_group got=%0d exp=10", sv_sum_q.size() == 1 ? sv_sum_q[0] : -1); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; en = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_en_pause();
    test_wrap();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
